// File: rtl/hazard_pkg.sv
// Shared constants and stage-entry field layout for the hazard scoreboard.
package hazard_pkg;

  // Pipeline stage indices tracked after ID (bit 0 of stage_valid is youngest).
  localparam int STAGE_EX  = 0;
  localparam int STAGE_MEM = 1;
  localparam int STAGE_WB  = 2;

  // Compare and forwarding-select constants.
  localparam int ZERO_REG = 0;
  localparam int FWD_RF   = 0;

  // Stage entry layout: {reg[REG_W-1:0], load, valid}.
  localparam int ENT_VALID = 0;
  localparam int ENT_LOAD  = 1;
  localparam int ENT_REG   = 2;

  function automatic int entry_w(input int reg_w);
    return reg_w + ENT_REG;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand compare against all pending writes plus youngest-first priority
// encode; forwarding select exists only with HAZARD_SCOREBOARD_FWD_EN.
module hazard_match
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3,
  parameter int REG_W = 5
) (
  input  logic [DEPTH-1:0]            valid,
  input  logic [DEPTH-1:0][REG_W-1:0] regs,
  input  logic [DEPTH-1:0]            load,
  input  logic                        use_src,
  input  logic [REG_W-1:0]            src,
  output logic                        hazard
`ifdef HAZARD_SCOREBOARD_FWD_EN
  , output logic [$clog2(DEPTH+1)-1:0] sel
`endif
);

`ifdef HAZARD_SCOREBOARD_FWD_EN
  localparam bit LOAD_USE_ONLY = 1'b1;
  localparam int SEL_W = $clog2(DEPTH+1);
`else
  localparam bit LOAD_USE_ONLY = 1'b0;
`endif

  logic [DEPTH-1:0] hit;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves it unassigned, which would infer a latch.
    hit = '0;
    for (int k = 0; k < DEPTH; k++) begin
      hit[k] = use_src && (src != REG_W'(ZERO_REG)) && valid[k] && (regs[k] == src);
    end
  end

  // With forwarding only a load still sitting in the youngest stage cannot be
  // bypassed; any younger-than-it match would already have been selected.
  assign hazard = LOAD_USE_ONLY ? (hit[STAGE_EX] & load[STAGE_EX]) : (|hit);

`ifdef HAZARD_SCOREBOARD_FWD_EN
  always_comb begin
    sel = SEL_W'(FWD_RF);
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit[k]) sel = SEL_W'(k + 1);
    end
  end
`endif

endmodule

// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: pending-write shift register, RAW stall
// and non-pipelined multiplier busy. Define HAZARD_SCOREBOARD_FWD_EN for bypassing.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int REG_W    = 5,
  parameter int DEPTH    = 3,
  parameter int MUL_LAT  = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [REG_W-1:0] id_wr_reg,
  input  logic             id_is_load,
  input  logic             id_is_mul,
  input  logic             flush,
  output logic             id_stall,
  output logic             mul_busy,
  output logic [DEPTH-1:0] stage_valid
`ifdef HAZARD_SCOREBOARD_FWD_EN
  , output logic [$clog2(DEPTH+1)-1:0] fwd_sel_rs
  , output logic [$clog2(DEPTH+1)-1:0] fwd_sel_rt
`endif
);

  localparam int ENT_W = entry_w(REG_W);
  localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  if ($clog2(NUM_REGS) != REG_W) begin : g_bad_reg_w
    $error("REG_W must equal clog2(NUM_REGS)");
  end

  logic [DEPTH-1:0][ENT_W-1:0] stage;
  logic [ENT_W-1:0]            new_entry;
  logic [CNT_W-1:0]            mul_cnt;
  logic [DEPTH-1:0]            st_valid;
  logic [DEPTH-1:0]            st_load;
  logic [DEPTH-1:0][REG_W-1:0] st_reg;
  logic                        hazard_rs;
  logic                        hazard_rt;
  logic                        issue;

  for (genvar k = 0; k < DEPTH; k++) begin : g_unpack
    assign st_valid[k] = stage[k][ENT_VALID];
    assign st_load[k]  = stage[k][ENT_LOAD];
    assign st_reg[k]   = stage[k][ENT_REG +: REG_W];
  end

  hazard_match #(.DEPTH(DEPTH), .REG_W(REG_W)) u_match_rs (
    .valid(st_valid), .regs(st_reg), .load(st_load),
    .use_src(id_use_rs), .src(id_rs), .hazard(hazard_rs)
`ifdef HAZARD_SCOREBOARD_FWD_EN
    , .sel(fwd_sel_rs)
`endif
  );

  hazard_match #(.DEPTH(DEPTH), .REG_W(REG_W)) u_match_rt (
    .valid(st_valid), .regs(st_reg), .load(st_load),
    .use_src(id_use_rt), .src(id_rt), .hazard(hazard_rt)
`ifdef HAZARD_SCOREBOARD_FWD_EN
    , .sel(fwd_sel_rt)
`endif
  );

  assign mul_busy    = (mul_cnt != '0);
  assign id_stall    = id_valid & (hazard_rs | hazard_rt | (id_is_mul & mul_busy));
  assign issue       = id_valid & ~id_stall & ~flush;
  assign stage_valid = st_valid;

  // Stalls and flushes both enter as bubbles because issue is low.
  always_comb begin
    new_entry                     = '0;
    new_entry[ENT_VALID]          = issue & id_wr_en & (id_wr_reg != REG_W'(ZERO_REG));
    new_entry[ENT_LOAD]           = id_is_load;
    new_entry[ENT_REG +: REG_W]   = id_wr_reg;
  end

  // NOTE: state uses non-blocking assignments so every stage samples its
  // neighbour's pre-edge value; the small stage array is reset with the rest.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      stage   <= '0;
      mul_cnt <= '0;
    end else begin
      stage[0] <= new_entry;
      for (int k = 1; k < DEPTH; k++) begin
        stage[k] <= stage[k-1];
      end
      if (issue && id_is_mul) begin
        mul_cnt <= CNT_W'(MUL_LAT - 1);
      end else if (mul_cnt != '0) begin
        mul_cnt <= mul_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed self-checking bench for hazard_scoreboard (DEPTH = 3, MUL_LAT = 4),
// with a MUL_LAT = 1 instance alongside; forwarding checks need HAZARD_SCOREBOARD_FWD_EN.
module tb_hazard_scoreboard;

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, id_is_mul, flush;
  logic [4:0] id_rs, id_rt, id_wr_reg;
  logic       id_stall, mul_busy;
  logic [2:0] stage_valid;
  logic       stall1, busy1;
  logic [2:0] sv1;
`ifdef HAZARD_SCOREBOARD_FWD_EN
  logic [1:0] fwd_sel_rs, fwd_sel_rt, fwd1_rs, fwd1_rt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  always #5 Clk = ~Clk;

  hazard_scoreboard #(.NUM_REGS(32), .REG_W(5), .DEPTH(3), .MUL_LAT(4)) u_dut (
    .Clk(Clk), .Rst_n(Rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .flush(flush), .id_stall(id_stall), .mul_busy(mul_busy), .stage_valid(stage_valid)
`ifdef HAZARD_SCOREBOARD_FWD_EN
    , .fwd_sel_rs(fwd_sel_rs), .fwd_sel_rt(fwd_sel_rt)
`endif
  );

  hazard_scoreboard #(.NUM_REGS(32), .REG_W(5), .DEPTH(3), .MUL_LAT(1)) u_dut_lat1 (
    .Clk(Clk), .Rst_n(Rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_reg(id_wr_reg), .id_is_load(id_is_load), .id_is_mul(id_is_mul),
    .flush(flush), .id_stall(stall1), .mul_busy(busy1), .stage_valid(sv1)
`ifdef HAZARD_SCOREBOARD_FWD_EN
    , .fwd_sel_rs(fwd1_rs), .fwd_sel_rt(fwd1_rt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs, input logic urs,
                       input logic [4:0] rt, input logic urt, input logic we,
                       input logic [4:0] wr, input logic ld, input logic mul,
                       input logic fl);
    id_valid = v;   id_rs = rs;       id_use_rs = urs; id_rt = rt; id_use_rt = urt;
    id_wr_en = we;  id_wr_reg = wr;   id_is_load = ld; id_is_mul = mul; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic sample();
    @(negedge Clk);
  endtask

  initial begin
    Rst_n = 1'b0;
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0);
    #2;
    check("reset_stage_valid", stage_valid, 3'b000);
    check("reset_mul_busy", mul_busy, 0);
    check("reset_stall", id_stall, 0);
    #5 Rst_n = 1'b1;
    tick();

    // RAW on r5: writer reads its own destination without stalling, reader waits 3 cycles.
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0);
    sample();
    check("self_hazard", id_stall, 0);
    tick();
    drive(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    #1 check("raw_unused_operand", id_stall, 0);
    id_use_rs = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("raw_stall_c%0d", i), id_stall, 1);
      check($sformatf("raw_stage_c%0d", i), stage_valid, 32'(3'b001 << i));
      tick();
    end
    sample();
    check("raw_released", id_stall, 0);
    check("raw_drained", stage_valid, 3'b000);
    tick();
    idle();

    // r0 writes never become pending.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0);
    sample();
    check("r0_write_stall", id_stall, 0);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    sample();
    check("r0_read_stall", id_stall, 0);
    check("r0_stage_valid", stage_valid, 3'b000);
    tick();
    idle();

    // Back-to-back multiplies: second one held while the unit is busy.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b0, 1'b1, 1'b0);
    sample();
    check("mul1_stall", id_stall, 0);
    check("mul1_busy_before", mul_busy, 0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("mul_busy_c%0d", i), mul_busy, 1);
      check($sformatf("mul2_stall_c%0d", i), id_stall, 1);
      check($sformatf("lat1_busy_c%0d", i), busy1, 0);
      check($sformatf("lat1_stall_c%0d", i), stall1, 0);
      if (i == 0) check("mul_stage_valid", stage_valid, 3'b001);
      tick();
    end
    sample();
    check("mul_free", mul_busy, 0);
    check("mul2_issue", id_stall, 0);
    tick();
    idle();
    sample();
    check("mul2_busy", mul_busy, 1);
    tick();
    tick();
    tick();
    sample();
    check("mul2_done", mul_busy, 0);
    check("mul2_drained", stage_valid, 3'b000);
    tick();

    // Flush against a stalled reader of r7: no new entry, r7 retires on time.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 1'b1);
    sample();
    check("flush_stall", id_stall, 1);
    check("flush_r7_ex", stage_valid, 3'b001);
    tick();
    sample();
    check("flush_r7_mem", stage_valid, 3'b010);
    tick();
    sample();
    check("flush_r7_wb", stage_valid, 3'b100);
    tick();
    sample();
    check("flush_r7_retired", stage_valid, 3'b000);
    check("flush_r7_nostall", id_stall, 0);
    id_is_mul = 1'b1;
    tick();
    sample();
    check("flush_no_entry", stage_valid, 3'b000);
    check("flush_no_mul_load", mul_busy, 0);
    tick();
    idle();

    // Asynchronous reset with three pending writes and a busy multiplier.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    sample();
    check("prerst_stage_valid", stage_valid, 3'b111);
    check("prerst_stall", id_stall, 1);
    check("prerst_busy", mul_busy, 1);
    #1 Rst_n = 1'b0;
    #1;
    check("rst_stage_valid", stage_valid, 3'b000);
    check("rst_stall", id_stall, 0);
    check("rst_busy", mul_busy, 0);
    #1 Rst_n = 1'b1;
    tick();
    sample();
    check("postrst_stall", id_stall, 0);
    check("postrst_stage_valid", stage_valid, 3'b000);
    tick();
    idle();

`ifdef HAZARD_SCOREBOARD_FWD_EN
    // Load-use costs one bubble, then bypass from MEM; ALU result bypasses from EX.
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    sample();
    check("fwd_load_use_stall", id_stall, 1);
    tick();
    sample();
    check("fwd_load_use_release", id_stall, 0);
    check("fwd_load_sel", fwd_sel_rs, 2);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
    sample();
    check("fwd_alu_stall", id_stall, 0);
    check("fwd_alu_sel", fwd_sel_rs, 1);
    tick();
    idle();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
